mac_stop_accum: RTL and testbench

- Downstream stage of the MAC multiply slice: consumes one registered product per cycle plus its registered (row, col, k) indices.
- Sums K products per result element into a full-width accumulator.
- Writes each finished C[i][j] to result SRAM C through a 2-entry output buffer with a ready handshake.
- Signals completion once all M*N elements have been written.

---
 rtl/mac_stop_accum.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mac_stop_accum.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stop_accum.sv
`default_nettype none
// ============================================================================
// Module   : mac_stop_accum
// Purpose  : Accumulation stage behind the MAC multiply slice. It sums K
//            products into each C[i][j] element. Finished elements go to
//            result SRAM C through a 2-entry output buffer that uses a ready
//            handshake. all_done pulses once all M*N elements are written.
// Ports    : clk, reset (async, active-high)
//            product_in/product_valid, a_row_idx/b_col_idx/k_idx : product in
//            c_we/c_wready/c_row_addr/c_col_addr/c_data          : SRAM C write
//            busy (RUN or DRAIN), all_done (1-cycle pulse),
//            overflow (sticky, element lost on a full buffer)
//            seq_err (sticky k_idx ordering error), present only with the
//            MAC_STOP_ACCUM_SEQ_CHECK_EN macro defined
// Revision : 1.0 - initial release
// ============================================================================
module mac_stop_accum #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_in,
  input  logic                                product_valid,
  input  logic [$clog2(M)-1:0]                a_row_idx,
  input  logic [$clog2(N)-1:0]                b_col_idx,
  input  logic [$clog2(K)-1:0]                k_idx,
  output logic                                c_we,
  input  logic                                c_wready,
  output logic [$clog2(M)-1:0]                c_row_addr,
  output logic [$clog2(N)-1:0]                c_col_addr,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] c_data,
  output logic                                busy,
  output logic                                all_done,
  output logic                                overflow
`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
  ,
  output logic                                seq_err
`endif
);

  localparam int c_row_w = $clog2(M);
  localparam int c_col_w = $clog2(N);
  localparam int c_k_w   = $clog2(K);
  localparam int c_res_w = DATA_WIDTH_RESULT_MATRIX;
  localparam int c_cnt_w = $clog2(M*N+1);

  localparam logic [c_cnt_w-1:0] c_total    = c_cnt_w'(M*N);
  localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(K-1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(M-1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [c_res_w-1:0]   acc_q;
  logic [c_cnt_w-1:0]   cnt_q,      cnt_d;

  // Buffer entry 0 is the head and drives the SRAM C port directly.
  // Entry 1 is only occupied while the head is still waiting.
  logic                 head_v_q,   head_v_d;
  logic [c_row_w-1:0]   head_row_q, head_row_d;
  logic [c_col_w-1:0]   head_col_q, head_col_d;
  logic [c_res_w-1:0]   head_dat_q, head_dat_d;
  logic                 tail_v_q,   tail_v_d;
  logic [c_row_w-1:0]   tail_row_q, tail_row_d;
  logic [c_col_w-1:0]   tail_col_q, tail_col_d;
  logic [c_res_w-1:0]   tail_dat_q, tail_dat_d;

  logic                 w_accept;     // product consumed this cycle
  logic                 w_abort;      // upstream stopped mid-run
  logic                 w_close;      // element finished, push requested
  logic                 w_last_elem;  // finished element is (M-1, N-1)
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_drain_end;  // DRAIN sees an empty buffer
  logic [c_res_w-1:0]   w_acc_next;

  assign c_we       = head_v_q;
  assign c_row_addr = head_row_q;
  assign c_col_addr = head_col_q;
  assign c_data     = head_dat_q;

  always_comb begin
    w_accept    = product_valid && (state_q == S_IDLE || state_q == S_RUN);
    w_abort     = !product_valid && (state_q == S_RUN);
    w_acc_next  = (k_idx == '0) ? c_res_w'(product_in)
                                : acc_q + c_res_w'(product_in);
    w_close     = w_accept && (k_idx == c_k_last);
    w_last_elem = w_close && (a_row_idx == c_row_last) && (b_col_idx == c_col_last);
    w_pop       = head_v_q && c_wready;
    // A simultaneous pop frees a slot, so a push into a full buffer is legal.
    w_push      = w_close && (!tail_v_q || w_pop);
    w_drop      = w_close && tail_v_q && !w_pop;
    w_drain_end = (state_q == S_DRAIN) && !head_v_q;
  end

  // Buffer next state: shift the tail forward on a pop, then place a new
  // element in the first free slot.
  always_comb begin
    head_v_d   = head_v_q;
    head_row_d = head_row_q;
    head_col_d = head_col_q;
    head_dat_d = head_dat_q;
    tail_v_d   = tail_v_q;
    tail_row_d = tail_row_q;
    tail_col_d = tail_col_q;
    tail_dat_d = tail_dat_q;
    if (w_pop) begin
      head_v_d   = tail_v_q;
      head_row_d = tail_row_q;
      head_col_d = tail_col_q;
      head_dat_d = tail_dat_q;
      tail_v_d   = 1'b0;
    end
    if (w_push) begin
      if (!head_v_d) begin
        head_v_d   = 1'b1;
        head_row_d = a_row_idx;
        head_col_d = b_col_idx;
        head_dat_d = w_acc_next;
      end else begin
        tail_v_d   = 1'b1;
        tail_row_d = a_row_idx;
        tail_col_d = b_col_idx;
        tail_dat_d = w_acc_next;
      end
    end
  end

  // The element counter restarts at every run boundary. This keeps leftovers
  // from an aborted or short run out of the next run's count.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_DONE) || w_abort || (state_q == S_IDLE && w_accept) ||
        (w_drain_end && cnt_q != c_total)) begin
      cnt_d = '0;
    end else if (w_pop) begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      head_v_q   <= 1'b0;
      head_row_q <= '0;
      head_col_q <= '0;
      head_dat_q <= '0;
      tail_v_q   <= 1'b0;
      tail_row_q <= '0;
      tail_col_q <= '0;
      tail_dat_q <= '0;
    end else begin
      if (w_abort || w_close) begin
        acc_q <= '0;
      end else if (w_accept) begin
        acc_q <= w_acc_next;
      end
      cnt_q      <= cnt_d;
      head_v_q   <= head_v_d;
      head_row_q <= head_row_d;
      head_col_q <= head_col_d;
      head_dat_q <= head_dat_d;
      tail_v_q   <= tail_v_d;
      tail_row_q <= tail_row_d;
      tail_col_q <= tail_col_d;
      tail_dat_q <= tail_dat_d;
    end
  end

  // Control FSM with registered busy / all_done / overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy     <= 1'b0;
      all_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      all_done <= 1'b0;
      if (state_q == S_IDLE && product_valid) begin
        overflow <= w_drop;
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (product_valid) begin
            state_q <= w_last_elem ? S_DRAIN : S_RUN;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!product_valid) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_last_elem) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_end) begin
            busy <= 1'b0;
            if (cnt_q == c_total) begin
              state_q  <= S_DONE;
              all_done <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
  logic [c_k_w-1:0] prev_k_q;
  logic [c_k_w-1:0] w_k_expect;

  // The first product of a run, or the first product after an element closes,
  // must carry k_idx 0. Otherwise k_idx must follow the previous one.
  always_comb begin
    if (state_q == S_IDLE || prev_k_q == c_k_last) begin
      w_k_expect = '0;
    end else begin
      w_k_expect = prev_k_q + c_k_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_k_q <= c_k_last;
      seq_err  <= 1'b0;
    end else if (w_accept) begin
      prev_k_q <= k_idx;
      if (state_q == S_IDLE) begin
        seq_err <= (k_idx != w_k_expect);
      end else if (k_idx != w_k_expect) begin
        seq_err <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_stop_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_stop_accum
// Purpose  : Self-checking bench for mac_stop_accum. One instance uses
//            M=N=K=2 with 8-bit operands. A second instance uses K=4 for the
//            full-scale accumulation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_stop_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // M=N=K=2, DW=8 instance
  logic [15:0] prod;
  logic        pv;
  logic [0:0]  row, col, k;
  logic        wready;
  logic        we;
  logic [0:0]  crow, ccol;
  logic [16:0] cdata;
  logic        busy, done, ovf;
`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
  logic        serr, serr4;
`endif

  // M=N=2, K=4, DW=8 instance
  logic [15:0] prod4;
  logic        pv4;
  logic [0:0]  row4, col4;
  logic [1:0]  k4;
  logic        wready4;
  logic        we4;
  logic [0:0]  crow4, ccol4;
  logic [17:0] cdata4;
  logic        busy4, done4, ovf4;

  mac_stop_accum #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) dut2 (
    .clk(clk), .reset(rst), .product_in(prod), .product_valid(pv),
    .a_row_idx(row), .b_col_idx(col), .k_idx(k),
    .c_we(we), .c_wready(wready), .c_row_addr(crow), .c_col_addr(ccol),
    .c_data(cdata), .busy(busy), .all_done(done), .overflow(ovf)
`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
    , .seq_err(serr)
`endif
  );

  mac_stop_accum #(.M(2), .K(4), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) dut4 (
    .clk(clk), .reset(rst), .product_in(prod4), .product_valid(pv4),
    .a_row_idx(row4), .b_col_idx(col4), .k_idx(k4),
    .c_we(we4), .c_wready(wready4), .c_row_addr(crow4), .c_col_addr(ccol4),
    .c_data(cdata4), .busy(busy4), .all_done(done4), .overflow(ovf4)
`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
    , .seq_err(serr4)
`endif
  );

  typedef struct {
    logic [0:0]  r;
    logic [0:0]  c;
    logic [0:0]  k;
    logic [15:0] p;
    logic [16:0] acc;   // expected running sum after this product
  } vec_t;

  typedef struct {
    logic [0:0]  r;
    logic [0:0]  c;
    logic [16:0] d;
  } exp_t;

  vec_t vt [8];
  exp_t sb [$];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every accepted SRAM C write is compared with the oldest
  // expected element.
  always @(negedge clk) begin
    if (!rst && we && wready) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("sb_expects_write", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_row", crow, mon_e.r);
        check("wr_col", ccol, mon_e.c);
        check("wr_data", cdata, mon_e.d);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done4) done4_cnt++;
  end

  // Drive vt[first .. first+count-1] back to back. The first `keep` finished
  // elements are expected to reach SRAM C. With lat set, each element must
  // appear on the port one cycle after its last product.
  task automatic stream(input int first, input int count, input int keep, input bit lat);
    for (int i = first; i < first + count; i++) begin
      pv   = 1'b1;
      row  = vt[i].r;
      col  = vt[i].c;
      k    = vt[i].k;
      prod = vt[i].p;
      if (vt[i].k == 1'b1 && keep > 0) begin
        sb.push_back('{r: vt[i].r, c: vt[i].c, d: vt[i].acc});
        keep--;
      end
      @(posedge clk); #1;
      if (lat && vt[i].k == 1'b1) begin
        check("latency_we", we, 1);
        check("latency_data", cdata, vt[i].acc);
      end
    end
    pv = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    vt[0] = '{1'b0, 1'b0, 1'b0, 16'd5,  17'd5};
    vt[1] = '{1'b0, 1'b0, 1'b1, 16'd14, 17'd19};
    vt[2] = '{1'b0, 1'b1, 1'b0, 16'd6,  17'd6};
    vt[3] = '{1'b0, 1'b1, 1'b1, 16'd16, 17'd22};
    vt[4] = '{1'b1, 1'b0, 1'b0, 16'd15, 17'd15};
    vt[5] = '{1'b1, 1'b0, 1'b1, 16'd28, 17'd43};
    vt[6] = '{1'b1, 1'b1, 1'b0, 16'd18, 17'd18};
    vt[7] = '{1'b1, 1'b1, 1'b1, 16'd32, 17'd50};

    pv = 1'b0; row = '0; col = '0; k = '0; prod = '0; wready = 1'b1;
    pv4 = 1'b0; row4 = '0; col4 = '0; k4 = '0; prod4 = '0; wready4 = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", cdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_we", we, 0);

    // Full 2x2 product, SRAM always ready
    wr_cnt = 0; done_cnt = 0;
    stream(0, 8, 4, 1'b1);
    wait_idle(20, "t1_idle");
    repeat (3) @(posedge clk);
    #1;
    check("t1_writes", wr_cnt, 4);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_done_after_last_write", (done_cyc > last_wr_cyc), 1);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_ovf", ovf, 0);

    // SRAM stalls: two elements buffered, the rest lost
    wready = 1'b0; wr_cnt = 0; done_cnt = 0;
    stream(0, 8, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t2_overflow", ovf, 1);
    check("t2_we_held", we, 1);
    check("t2_head_data", cdata, 19);
    check("t2_busy_drain", busy, 1);
    wready = 1'b1;
    wait_idle(20, "t2_idle");
    repeat (3) @(posedge clk);
    #1;
    check("t2_writes", wr_cnt, 2);
    check("t2_no_done", done_cnt, 0);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_ovf_sticky", ovf, 1);

    // Upstream aborts after k=0 of element (1,0), then a clean run
    wr_cnt = 0; done_cnt = 0;
    stream(0, 5, 2, 1'b0);
    check("t3_ovf_cleared", ovf, 0);
    @(posedge clk); #1;
    check("t3_abort_idle", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_abort_writes", wr_cnt, 2);
    check("t3_abort_no_done", done_cnt, 0);
    wr_cnt = 0;
    stream(0, 8, 4, 1'b1);
    wait_idle(20, "t3_rerun_idle");
    repeat (3) @(posedge clk);
    #1;
    check("t3_rerun_writes", wr_cnt, 4);
    check("t3_rerun_done", done_cnt, 1);
    check("t3_sb_empty", sb.size(), 0);

    // Reset while the buffer holds two entries
    wready = 1'b0; wr_cnt = 0;
    stream(0, 4, 0, 1'b0);
    @(posedge clk); #1;
    check("t4_we_before_rst", we, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_we_async", we, 0);
    check("t4_busy_async", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t4_no_writes", wr_cnt, 0);
    check("t4_we_idle", we, 0);

    // Full-scale products, K=4: 4 * 255*255 must not truncate
    done4_cnt = 0;
    for (int e = 0; e < 4; e++) begin
      for (int kk = 0; kk < 4; kk++) begin
        pv4 = 1'b1; row4 = e[1]; col4 = e[0]; k4 = kk[1:0]; prod4 = 16'd65025;
        @(posedge clk); #1;
        if (kk == 3) begin
          check("t5_we", we4, 1);
          check("t5_data", cdata4, 18'd260100);
          check("t5_row", crow4, e[1]);
          check("t5_col", ccol4, e[0]);
        end
      end
    end
    pv4 = 1'b0;
    for (int n = 0; n < 20 && busy4; n++) begin
      @(posedge clk); #1;
    end
    check("t5_idle", busy4, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_done", done4_cnt, 1);
    check("t5_ovf", ovf4, 0);

`ifdef MAC_STOP_ACCUM_SEQ_CHECK_EN
    // k_idx sequence 0,0,1: error is flagged and persists until a new run
    wr_cnt = 0; done_cnt = 0;
    pv = 1'b1; row = 1'b0; col = 1'b0; k = 1'b0; prod = 16'd5;
    @(posedge clk); #1;
    check("t6_serr_first", serr, 0);
    @(posedge clk); #1;
    check("t6_serr_set", serr, 1);
    k = 1'b1; prod = 16'd14;
    sb.push_back('{r: 1'b0, c: 1'b0, d: 17'd19});
    @(posedge clk); #1;
    check("t6_serr_sticky_run", serr, 1);
    pv = 1'b0;
    @(posedge clk); #1;
    check("t6_abort_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_serr_sticky_idle", serr, 1);
    stream(0, 8, 4, 1'b1);
    check("t6_serr_cleared", serr, 0);
    wait_idle(20, "t6_idle");
    repeat (3) @(posedge clk);
    #1;
    check("t6_writes", wr_cnt, 5);
    check("t6_done", done_cnt, 1);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_serr4", serr4, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
